// File: rtl/arb_pkg.sv
// Shared types and helpers for the FIFO round-robin read scheduler.
package arb_pkg;

  localparam int GRANT_CNT_W = 16;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping
// past NUM_REQ-1 back to 0. Purely combinational.
module rr_priority_pick import arb_pkg::*; #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx,
  output logic [NUM_REQ-1:0]  onehot
);

  logic [ID_WIDTH:0] cand;

  // Scan from the far end so the last hit written is the nearest to ptr.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
      if (cand >= (ID_WIDTH + 1)'(NUM_REQ)) cand = cand - (ID_WIDTH + 1)'(NUM_REQ);
      if (req[cand[ID_WIDTH-1:0]]) begin
        any = 1'b1;
        idx = cand[ID_WIDTH-1:0];
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler popping one fall-through FIFO per cycle into a
// registered valid/ready output slot tagged with the source index.
//
// state     | meaning
// OUT_EMPTY | output slot holds no word, out_valid=0
// OUT_FULL  | output slot holds a word waiting for out_ready
module fifo_rr_arbiter import arb_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_REQ-1:0]            fifo_rd_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [clog2(NUM_REQ)-1:0]     out_id,
  output logic [GRANT_CNT_W-1:0]        grant_cnt
);

  localparam int ID_WIDTH = clog2(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

  out_state_e            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic                  can_load;
  logic [DATA_WIDTH-1:0] head_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_head
    assign head_word[i] = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (~fifo_empty),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign can_load   = arb_en && (!out_valid || out_ready) && pick_any;
  assign fifo_rd_en = (can_load && !reset) ? pick_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OUT_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else begin
      if (out_valid && out_ready && (grant_cnt != '1))
        grant_cnt <= grant_cnt + GRANT_CNT_W'(1);

      case (state)
        OUT_EMPTY: begin
          if (can_load) begin
            state     <= OUT_FULL;
            out_valid <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (!can_load && out_ready) begin
            state     <= OUT_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= OUT_EMPTY;
          out_valid <= 1'b0;
        end
      endcase

      // Pointer moves past the winner so it gets lowest priority next time.
      if (can_load) begin
        out_data <= head_word[pick_idx];
        out_id   <= pick_idx;
        rr_ptr   <= (pick_idx == LAST_IDX) ? '0 : pick_idx + ID_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: queue-modelled FIFOs, a vector table for
// the round-robin sequences and hand-written multi-cycle corner cases.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset, arb_en, out_ready;
  logic [3:0]  fifo_empty, fifo_rd_en;
  logic [31:0] fifo_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic [15:0] grant_cnt;

  logic [2:0]  b_fifo_empty, b_fifo_rd_en;
  logic [23:0] b_fifo_data;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_id;
  logic [15:0] b_grant_cnt;

  fifo_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) dut_a (
    .clk(clk), .reset(reset), .arb_en(arb_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .grant_cnt(grant_cnt)
  );

  fifo_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3)) dut_b (
    .clk(clk), .reset(reset), .arb_en(arb_en), .fifo_empty(b_fifo_empty),
    .fifo_data(b_fifo_data), .fifo_rd_en(b_fifo_rd_en), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_id(b_out_id),
    .grant_cnt(b_grant_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] qa [4][$];
  logic [7:0] qb [3][$];
  logic [3:0] rd_a;
  logic [2:0] rd_b;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  rd;
    logic        valid;
    logic [1:0]  id;
    logic [7:0]  data;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]     = (qa[i].size() == 0);
      fifo_data[i*8 +: 8] = (qa[i].size() == 0) ? 8'h00 : qa[i][0];
    end
    for (int i = 0; i < 3; i++) begin
      b_fifo_empty[i]     = (qb[i].size() == 0);
      b_fifo_data[i*8 +: 8] = (qb[i].size() == 0) ? 8'h00 : qb[i][0];
    end
  endtask

  // One clock: settle inputs, capture pop strobes, clock, apply pops to queues.
  task automatic step();
    drive();
    #1;
    rd_a = fifo_rd_en;
    rd_b = b_fifo_rd_en;
    @(posedge clk);
    #1;
    chk("rd_onehot", 32'($countones(rd_a) <= 1 && $countones(rd_b) <= 1), 32'd1);
    for (int i = 0; i < 4; i++)
      if (rd_a[i]) begin
        chk("pop_nonempty_a", 32'(qa[i].size() != 0), 32'd1);
        if (qa[i].size() != 0) void'(qa[i].pop_front());
      end
    for (int i = 0; i < 3; i++)
      if (rd_b[i]) begin
        chk("pop_nonempty_b", 32'(qb[i].size() != 0), 32'd1);
        if (qb[i].size() != 0) void'(qb[i].pop_front());
      end
    drive();
  endtask

  task automatic apply(input int n);
    step();
    chk($sformatf("tbl%0d_rd", n),    32'(rd_a),      32'(tbl[n].rd));
    chk($sformatf("tbl%0d_valid", n), 32'(out_valid), 32'(tbl[n].valid));
    chk($sformatf("tbl%0d_id", n),    32'(out_id),    32'(tbl[n].id));
    chk($sformatf("tbl%0d_data", n),  32'(out_data),  32'(tbl[n].data));
    chk($sformatf("tbl%0d_cnt", n),   32'(grant_cnt), 32'(tbl[n].cnt));
  endtask

  initial begin
    for (int k = 0; k < 12; k++)
      tbl[k] = '{rd: 4'(1 << (k % 4)), valid: 1'b1, id: 2'(k % 4),
                 data: {4'(k % 4), 4'(k / 4)}, cnt: 16'(k)};
    tbl[12] = '{rd: 4'b0000, valid: 1'b0, id: 2'd3, data: 8'h32, cnt: 16'd12};
    for (int j = 0; j < 4; j++)
      tbl[13 + j] = '{rd: 4'b0100, valid: 1'b1, id: 2'd2, data: 8'hA0 + 8'(j), cnt: 16'(12 + j)};
    tbl[17] = '{rd: 4'b0000, valid: 1'b0, id: 2'd2, data: 8'hA3, cnt: 16'd16};

    reset = 1'b1; arb_en = 1'b1; out_ready = 1'b1;
    drive();
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_cnt",   32'(grant_cnt), 32'd0);
    chk("rst_ptr",   32'(dut_a.rr_ptr), 32'd0);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    reset = 1'b0;

    // All empty: nothing moves.
    repeat (10) begin
      step();
      chk("idle_rd",    32'(rd_a),      32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_cnt",   32'(grant_cnt), 32'd0);
    end

    // Four FIFOs, three words each: strict rotation 0,1,2,3.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) qa[i].push_back({4'(i), 4'(k)});
    for (int n = 0; n <= 12; n++) apply(n);
    chk("rot_ptr", 32'(dut_a.rr_ptr), 32'd0);

    // Single nonempty FIFO: back-to-back grants, no bubbles.
    for (int k = 0; k < 4; k++) qa[2].push_back(8'hA0 + 8'(k));
    for (int n = 13; n <= 17; n++) apply(n);
    chk("single_ptr", 32'(dut_a.rr_ptr), 32'd3);

    // Backpressure: word from FIFO 1 held while out_ready low.
    qa[1].push_back(8'h55);
    step();
    chk("bp_rd0", 32'(rd_a), 32'b0010);
    chk("bp_id0", 32'(out_id), 32'd1);
    out_ready = 1'b0;
    qa[0].push_back(8'h66);
    qa[3].push_back(8'h77);
    repeat (5) begin
      step();
      chk("bp_hold_rd",    32'(rd_a),      32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_id",    32'(out_id),    32'd1);
      chk("bp_hold_data",  32'(out_data),  32'h55);
      chk("bp_hold_cnt",   32'(grant_cnt), 32'd16);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_rd",   32'(rd_a),     32'b1000);
    chk("bp_next_id",   32'(out_id),   32'd3);
    chk("bp_next_data", 32'(out_data), 32'h77);
    step();
    chk("bp_wrap_id",   32'(out_id),   32'd0);
    chk("bp_wrap_data", 32'(out_data), 32'h66);
    step();
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    chk("bp_end_cnt",   32'(grant_cnt), 32'd19);

    // arb_en low: held word drains, no new pops.
    qa[0].push_back(8'h81); qa[0].push_back(8'h82); qa[1].push_back(8'h91);
    step();
    chk("en_id", 32'(out_id), 32'd1);
    chk("en_data", 32'(out_data), 32'h91);
    arb_en = 1'b0;
    step();
    chk("en_drain_valid", 32'(out_valid), 32'd0);
    chk("en_drain_cnt",   32'(grant_cnt), 32'd20);
    repeat (3) begin
      step();
      chk("en_off_rd",    32'(rd_a),      32'd0);
      chk("en_off_valid", 32'(out_valid), 32'd0);
    end
    chk("en_off_q0", 32'(qa[0].size()), 32'd2);
    arb_en = 1'b1;
    step();
    chk("en_on_rd",   32'(rd_a),     32'b0001);
    chk("en_on_data", 32'(out_data), 32'h81);
    step();
    chk("en_on2_data", 32'(out_data), 32'h82);
    chk("en_on2_cnt",  32'(grant_cnt), 32'd21);
    step();
    chk("en_end_cnt", 32'(grant_cnt), 32'd22);

    // NUM_REQ=3 instance: wrap from index 2 back to 0.
    for (int i = 0; i < 3; i++) begin
      qb[i].push_back(8'hB0 + 8'(i));
      qb[i].push_back(8'hC0 + 8'(i));
    end
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("wrap%0d_rd", n),   32'(rd_b),       32'(3'b001 << (n % 3)));
      chk($sformatf("wrap%0d_id", n),   32'(b_out_id),   32'(n % 3));
      chk($sformatf("wrap%0d_data", n), 32'(b_out_data), (n < 3) ? 32'hB0 + 32'(n) : 32'hC0);
    end
    chk("wrap_ptr", 32'(dut_b.rr_ptr), 32'd1);
    repeat (3) step();
    chk("wrap_end_valid", 32'(b_out_valid), 32'd0);
    chk("wrap_end_cnt",   32'(b_grant_cnt), 32'd6);

    // Reset with a word in the output register.
    qa[1].push_back(8'hC1); qa[1].push_back(8'hC2);
    step();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_data",  32'(out_data),  32'hC1);
    reset = 1'b1;
    step();
    chk("mid_rd",    32'(rd_a),          32'd0);
    chk("mid_valid", 32'(out_valid),     32'd0);
    chk("mid_ptr",   32'(dut_a.rr_ptr),  32'd0);
    chk("mid_cnt",   32'(grant_cnt),     32'd0);
    chk("mid_data",  32'(out_data),      32'd0);
    chk("mid_q1",    32'(qa[1].size()),  32'd1);
    chk("mid_b_cnt", 32'(b_grant_cnt),   32'd0);
    reset = 1'b0;
    step();
    chk("post_rd",   32'(rd_a),     32'b0010);
    chk("post_data", 32'(out_data), 32'hC2);
    step();
    chk("post_cnt",  32'(grant_cnt), 32'd1);

    // Saturation: counter equals step number while streaming from FIFO 0.
    for (int k = 0; k < 65536; k++) qa[0].push_back(8'hEE);
    for (int k = 1; k <= 65536; k++) begin
      step();
      if (k == 65534) chk("sat_fffe", 32'(grant_cnt), 32'hFFFE);
      if (k == 65535) chk("sat_ffff", 32'(grant_cnt), 32'hFFFF);
      if (k == 65536) chk("sat_hold", 32'(grant_cnt), 32'hFFFF);
    end
    step();
    chk("sat_final_cnt",   32'(grant_cnt), 32'hFFFF);
    chk("sat_final_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
